// File: rtl/modmul_pow2_pkg.sv
// Shared definitions for the modmul_pow2 slice: FSM state encoding and the
// exponent-width helper used to size the k port and the step counter.
package modmul_pow2_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Width of an exponent field able to hold 0..logn; never narrower than 1 bit.
    function automatic int exp_width(input int logn);
        return (logn < 1) ? 1 : $clog2(logn + 1);
    endfunction

endpackage

// File: rtl/modmul_pow2_if.sv
// Operand/result handshake bundle for modmul_pow2.
// master: the side offering operands and consuming results.
// slave:  the modular-scaling block itself.
interface modmul_pow2_if #(
    parameter int LOGQ = 0,
    parameter int LOGN = 0
);
    import modmul_pow2_pkg::*;

    localparam int KW = exp_width(LOGN);

    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] x;
    logic [LOGQ-1:0] q;
    logic [KW-1:0]   k;
    logic            out_valid;
    logic            out_ready;
    logic [LOGQ-1:0] y;
    logic            busy;

    modport master (
        output in_valid, x, q, k, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, x, q, k, out_ready,
        output in_ready, out_valid, y, busy
    );

endinterface

// File: rtl/mod_double.sv
// One modular doubling step: r = 2*a mod q for a < q, q odd.
// Purely combinational; shared with other scaling blocks.
module mod_double #(
    parameter int LOGQ = 2
) (
    input  logic [LOGQ-1:0] a,
    input  logic [LOGQ-1:0] q,
    output logic [LOGQ-1:0] r
);

    logic [LOGQ:0] t;
    logic [LOGQ:0] q_ext;
    logic [LOGQ:0] diff;

    assign t     = {a, 1'b0};
    assign q_ext = {1'b0, q};
    assign diff  = t - q_ext;

    // Compare and subtract at LOGQ+1 bits so 2*a never overflows; the kept
    // result is < q and therefore fits back into LOGQ bits.
    always_comb begin
        r = t[LOGQ-1:0];
        if (t >= q_ext) begin
            r = diff[LOGQ-1:0];
        end
    end

endmodule

// File: rtl/modmul_pow2.sv
// Multi-cycle x*2^k mod q by k iterated modular doublings (inverse of the
// halving used in INTT scaling). One operation in flight at a time.
// Optional build macro MODMUL_POW2_PRERED_EN: reduce x once at latch so that
// operands up to 2q-1 are accepted.
module modmul_pow2
    import modmul_pow2_pkg::*;
#(
    parameter int LOGQ = 0,
    parameter int LOGN = 0
) (
    input logic            clk,
    input logic            rstn,
    modmul_pow2_if.slave   bus
);

    localparam int KW = exp_width(LOGN);
    localparam logic [KW-1:0] KMax = KW'(LOGN);

    state_e          state_q, state_d;
    logic [LOGQ-1:0] acc_q, acc_d;
    logic [LOGQ-1:0] q_r_q, q_r_d;
    logic [KW-1:0]   cnt_q, cnt_d;

    logic [LOGQ-1:0] x_lat;
    logic [KW-1:0]   k_lat;
    logic [LOGQ-1:0] dbl_r;

    mod_double #(
        .LOGQ (LOGQ)
    ) u_mod_double (
        .a (acc_q),
        .q (q_r_q),
        .r (dbl_r)
    );

    // Operand conditioning at latch time: clamp k, optionally pre-reduce x.
    always_comb begin
        k_lat = bus.k;
        if (bus.k > KMax) begin
            k_lat = KMax;
        end
`ifdef MODMUL_POW2_PRERED_EN
        x_lat = bus.x;
        if (bus.x >= bus.q) begin
            x_lat = bus.x - bus.q;
        end
`else
        x_lat = bus.x;
`endif
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            acc_q   <= '0;
            q_r_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_r_q   <= q_r_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_r_d   = q_r_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    acc_d   = x_lat;
                    q_r_d   = bus.q;
                    cnt_d   = k_lat;
                    state_d = (k_lat != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                acc_d = dbl_r;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == KW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode from registered state only; y is the accumulator register.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.busy      = (state_q != StIdle);
        bus.y         = acc_q;
    end

endmodule

// File: tb/tb_modmul_pow2.sv
// Self-checking bench for modmul_pow2: directed cases, backpressure, mid-run
// reset and a randomized sweep against an arithmetic reference model.
// Honours MODMUL_POW2_PRERED_EN for the extended-input case.
module tb_modmul_pow2;

    localparam int LOGQ = 14;
    localparam int LOGN = 10;
    localparam int KW   = $clog2(LOGN + 1);

    logic clk;
    logic rstn;

    int n_checks;
    int n_fail;

    modmul_pow2_if #(.LOGQ(LOGQ), .LOGN(LOGN)) bus ();

    modmul_pow2 #(
        .LOGQ (LOGQ),
        .LOGN (LOGN)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // x * 2^min(k, LOGN) mod q, in plain integer arithmetic.
    function automatic int ref_model(input int x, input int q, input int k);
        longint p;
        int kk;
        kk = (k > LOGN) ? LOGN : k;
        p  = longint'(x) * (longint'(1) << kk);
        return int'(p % longint'(q));
    endfunction

    // Runs one operand through the DUT. Returns y and the number of edges after
    // the accepting edge before out_valid was seen (-1 on timeout).
    task automatic run_op(input int x, input int q, input int k, input bit scramble,
                          input bit handshake, output int y, output int lat);
        int waits;
        y = -1;
        lat = -1;
        waits = 0;
        while (bus.in_ready !== 1'b1 && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (bus.in_ready !== 1'b1) return;
        bus.x = LOGQ'(x);
        bus.q = LOGQ'(q);
        bus.k = KW'(k);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int c = 0; c < LOGN + 5; c++) begin
            if (bus.out_valid === 1'b1) begin
                lat = c;
                break;
            end
            if (scramble) begin
                bus.x = LOGQ'($urandom);
                bus.q = LOGQ'($urandom);
                bus.k = KW'($urandom);
                bus.in_valid = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (lat < 0) return;
        y = int'(bus.y);
        if (handshake) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.in_valid = 1'b1;
        bus.x = LOGQ'(77);
        bus.q = LOGQ'(7681);
        bus.k = KW'(2);
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0
            || bus.y !== '0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b busy=%b y=%0d, want 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.busy, bus.y);
        end
        bus.in_valid = 1'b0;
        #3 rstn = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        int y, lat;
        run_op(5, 7681, 3, 1'b0, 1'b1, y, lat);
        n_checks++;
        if (y !== 40) begin
            n_fail++;
            $display("FAIL basic_y: got %0d want 40", y);
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_wrap();
        int y, lat;
        run_op(7680, 7681, 1, 1'b0, 1'b1, y, lat);
        n_checks++;
        if (y !== 7679) begin
            n_fail++;
            $display("FAIL wrap_7680: got %0d want 7679", y);
        end
        run_op(3841, 7681, 1, 1'b0, 1'b1, y, lat);
        n_checks++;
        if (y !== 1) begin
            n_fail++;
            $display("FAIL wrap_3841: got %0d want 1", y);
        end
    endtask

    task automatic test_zero_exp();
        int y, lat;
        run_op(1234, 7681, 0, 1'b0, 1'b1, y, lat);
        n_checks++;
        if (y !== 1234 || lat !== 0) begin
            n_fail++;
            $display("FAIL zero_k: got y=%0d lat=%0d want y=1234 lat=0", y, lat);
        end
        run_op(0, 12289, LOGN, 1'b0, 1'b1, y, lat);
        n_checks++;
        if (y !== 0 || lat !== LOGN) begin
            n_fail++;
            $display("FAIL zero_x: got y=%0d lat=%0d want y=0 lat=%0d", y, lat, LOGN);
        end
    endtask

    task automatic test_clamp();
        int y, lat;
        run_op(5, 7681, 15, 1'b0, 1'b1, y, lat);
        n_checks++;
        if (y !== 5120 || lat !== LOGN) begin
            n_fail++;
            $display("FAIL clamp_k: got y=%0d lat=%0d want y=5120 lat=%0d", y, lat, LOGN);
        end
    endtask

    task automatic test_backpressure();
        int y, lat;
        bit bad;
        run_op(1000, 12289, 2, 1'b0, 1'b0, y, lat);
        n_checks++;
        if (y !== 4000) begin
            n_fail++;
            $display("FAIL bp_result: got %0d want 4000", y);
        end
        bad = 1'b0;
        bus.in_valid = 1'b1;
        bus.x = LOGQ'(9);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || int'(bus.y) !== 4000)
                bad = 1'b1;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_hold: out_valid=%b in_ready=%b y=%0d want 1 0 4000",
                     bus.out_valid, bus.in_ready, bus.y);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_stability();
        int y, lat;
        run_op(4321, 7681, 7, 1'b1, 1'b1, y, lat);
        n_checks++;
        if (y !== ref_model(4321, 7681, 7) || lat !== 7) begin
            n_fail++;
            $display("FAIL stability: got y=%0d lat=%0d want y=%0d lat=7",
                     y, lat, ref_model(4321, 7681, 7));
        end
    endtask

    task automatic test_mid_reset();
        int y, lat;
        bus.x = LOGQ'(100);
        bus.q = LOGQ'(7681);
        bus.k = KW'(8);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_running: busy=%b in_ready=%b want 1 0",
                     bus.busy, bus.in_ready);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0
            || bus.y !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_abort: out_valid=%b in_ready=%b busy=%b y=%0d",
                     bus.out_valid, bus.in_ready, bus.busy, bus.y);
        end
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_idle: out_valid=%b in_ready=%b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
        run_op(100, 7681, 8, 1'b0, 1'b1, y, lat);
        n_checks++;
        if (y !== 2557) begin
            n_fail++;
            $display("FAIL mid_reset_recover: got %0d want 2557", y);
        end
    endtask

`ifdef MODMUL_POW2_PRERED_EN
    task automatic test_prered();
        int y, lat;
        run_op(7684, 7681, 2, 1'b0, 1'b1, y, lat);
        n_checks++;
        if (y !== 12) begin
            n_fail++;
            $display("FAIL prered: got %0d want 12", y);
        end
    endtask
`endif

    task automatic test_random_sweep();
        int qs[2];
        int y, lat, x, exp_y, xmax;
        qs[0] = 7681;
        qs[1] = 12289;
        foreach (qs[i]) begin
`ifdef MODMUL_POW2_PRERED_EN
            xmax = 2 * qs[i] - 1;
            if (xmax > (1 << LOGQ) - 1) xmax = (1 << LOGQ) - 1;
`else
            xmax = qs[i] - 1;
`endif
            for (int k = 0; k <= LOGN + 2; k++) begin
                for (int r = 0; r < 3; r++) begin
                    x = int'($urandom_range(xmax, 0));
                    exp_y = ref_model(x, qs[i], k);
                    run_op(x, qs[i], k, r == 2, 1'b1, y, lat);
                    n_checks++;
                    if (y !== exp_y || lat !== ((k > LOGN) ? LOGN : k)) begin
                        n_fail++;
                        $display("FAIL sweep q=%0d x=%0d k=%0d: got y=%0d lat=%0d want y=%0d",
                                 qs[i], x, k, y, lat, exp_y);
                    end
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rstn = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.x = '0;
        bus.q = '0;
        bus.k = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_exp();
        test_clamp();
        test_backpressure();
        test_stability();
        test_mid_reset();
`ifdef MODMUL_POW2_PRERED_EN
        test_prered();
`endif
        test_random_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/modmul_pow2.md
MODMUL_POW2 -- requirements
Module: modmul_pow2

Interface
REQ-001 SHALL have parameter LOGQ, default 0, meaning coefficient and modulus width in bits; legal values are at least 2 and must be set at instantiation.
REQ-002 SHALL have parameter LOGN, default 0, meaning the maximum shift exponent; legal values are at least 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand.
REQ-007 SHALL have port x, input, LOGQ bits: operand, with 0 <= x < q.
REQ-008 SHALL have port q, input, LOGQ bits: odd modulus with q >= 3.
REQ-009 SHALL have port k, input, $clog2(LOGN+1) bits: exponent, with 0 <= k <= LOGN.
REQ-010 SHALL have port out_valid, output, 1 bit: result y is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts y.
REQ-012 SHALL have port y, output, LOGQ bits: result, equal to x*2^k mod q.
REQ-013 SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-014 SHALL compute x*2^k mod q as k iterated modular doublings; it is the inverse of the halving used in INTT scaling.
REQ-015 Each doubling step SHALL work as follows:
- form t = {acc, 1'b0} at LOGQ+1 bits;
- the next acc is t-q if t >= q, otherwise t;
- the comparison and subtraction use LOGQ+1 bits, so there is no overflow for any q < 2^LOGQ.
REQ-016 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1. On in_valid, SHALL latch acc=x, q_r=q and cnt=k. Next state is RUN if k != 0, otherwise DONE.
REQ-018 RUN: each cycle SHALL perform one doubling and decrement cnt. When cnt reaches 1, the last doubling is performed and the next state is DONE.
REQ-019 DONE: out_valid=1 and y=acc, held stable until out_ready=1. On the handshake the next state is IDLE.
REQ-020 Latency SHALL be k+1 cycles from the accepting edge to the first cycle of out_valid; throughput is one result per k+2 cycles at best.
REQ-021 in_ready SHALL be 0 in RUN and DONE, and in_valid SHALL be ignored there; there is no overlap of operations.
REQ-022 Changes to the q, x and k ports after acceptance SHALL have no effect on the operation in flight.
REQ-023 A k greater than LOGN SHALL be clamped to LOGN at latch.
REQ-024 y SHALL be driven from a register only; there is no combinational path from inputs to outputs.

Reset
REQ-025 While rstn=0, SHALL hold state=IDLE, acc=0, q_r=0 and cnt=0, giving out_valid=0, busy=0, y=0 and in_ready=1.
REQ-026 Reset during RUN or DONE SHALL abort the operation immediately; no out_valid is produced for the aborted operand.
REQ-027 Reset deassertion SHALL be usable asynchronously; the first accept can occur on the first rising edge with rstn=1.

Configuration
REQ-028 With macro MODMUL_POW2_PRERED_EN defined, the IDLE latch SHALL store x-q when x >= q (one conditional subtraction), extending the legal input range to x < 2q.
REQ-029 Without MODMUL_POW2_PRERED_EN, x SHALL be latched unchanged, and x >= q is undefined use.

Structure
REQ-030 A shared package SHALL hold the state encoding typedef (IDLE/RUN/DONE) and the exponent width constant function.
REQ-031 The single doubling step SHALL be a combinational sub-module mod_double (inputs a and q, output r), reusable by other scaling blocks.

Verification
REQ-032 Basic doubling: q=7681, x=5, k=3 -> y=40, with out_valid in the 4th cycle after accept.
REQ-033 Wrap case: q=7681, x=7680, k=1 -> y=7679; and x=3841, k=1 -> y=1.
REQ-034 Zero exponent: k=0, x=1234 -> y=1234, with out_valid 1 cycle after accept; also x=0, k=LOGN -> y=0.
REQ-035 Backpressure and stability:
- out_ready held 0 for 5 cycles in DONE keeps y and out_valid stable and in_ready=0;
- input changes during RUN do not alter the result.
REQ-036 Mid-operation reset: rstn pulsed low in RUN -> the next cycle shows IDLE, out_valid=0 and in_ready=1, and a new operand then completes correctly.
REQ-037 With MODMUL_POW2_PRERED_EN: q=7681, x=7684, k=2 -> y=12; without the macro the case is excluded. Random sweep against a reference model for q in {7681, 12289} and all k.
